// File: rtl/pingpong_buf_pkg.sv
// rtl/pingpong_buf_pkg.sv - shared types and helpers for the ping-pong BRAM buffer
package pingpong_buf_pkg;

    typedef logic bank_idx_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;

    function automatic int lane_ratio(input int ex_width, input int ld_width);
        return ex_width / ld_width;
    endfunction

    function automatic int lane_sel_bits(input int ex_width, input int ld_width);
        return $clog2(ex_width / ld_width);
    endfunction

endpackage

// File: rtl/bram_sdp_lane_core.sv
// rtl/bram_sdp_lane_core.sv - common-clock SDP memory with per-lane writes and enabled read pipeline
module bram_sdp_lane_core #(
    parameter int    LANE_WIDTH       = 64,
    parameter int    LANES            = 4,
    parameter int    DEPTH            = 512,
    parameter int    READ_LATENCY     = 2,
    parameter string MEMORY_PRIMITIVE = "auto",
    localparam int   WIDTH            = LANES * LANE_WIDTH,
    localparam int   ADDR_WIDTH       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        wr_lane_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [LANE_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [READ_LATENCY-1:0] stage_en,
    output logic [WIDTH-1:0]        rd_data
);

    if (MEMORY_PRIMITIVE == "") begin : g_bad_primitive
        $error("MEMORY_PRIMITIVE must name a memory style");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pipe [READ_LATENCY];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_en[i]) begin
                mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data;
            end
        end
    end

    // Each stage only advances with its own valid token, so the last stage holds
    // the most recent delivered word between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (stage_en[0]) begin
                pipe[0] <= mem[rd_addr];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                if (stage_en[k]) begin
                    pipe[k] <= pipe[k-1];
                end
            end
        end
    end

    assign rd_data = pipe[READ_LATENCY-1];

endmodule

// File: rtl/bram_pingpong_buf.sv
// rtl/bram_pingpong_buf.sv - two-bank ping-pong buffer, narrow loader writes, wide executor reads
module bram_pingpong_buf
    import pingpong_buf_pkg::*;
#(
    parameter int    LD_DATA_WIDTH    = 64,
    parameter int    EX_DATA_WIDTH    = 256,
    parameter int    EX_DEPTH         = 256,
    parameter int    READ_LATENCY     = 2,
    parameter string MEMORY_PRIMITIVE = "auto",
    localparam int   EX_ADDR_WIDTH    = $clog2(EX_DEPTH),
    localparam int   LD_ADDR_WIDTH    = EX_ADDR_WIDTH + lane_sel_bits(EX_DATA_WIDTH, LD_DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_wr_en,
    input  logic [LD_ADDR_WIDTH-1:0] ld_addr,
    input  logic [LD_DATA_WIDTH-1:0] ld_data,
    output logic                     ld_ready,
    input  logic                     ld_commit,
    input  logic                     ex_rd_en,
    input  logic [EX_ADDR_WIDTH-1:0] ex_addr,
    output logic                     ex_bank_valid,
    input  logic                     ex_release,
    output logic [EX_DATA_WIDTH-1:0] ex_data,
    output logic                     ex_data_valid,
    output logic                     ld_bank,
    output logic                     ex_bank,
    output logic                     err_overrun,
    output logic                     err_underrun
);

    localparam int R         = lane_ratio(EX_DATA_WIDTH, LD_DATA_WIDTH);
    localparam int LANE_BITS = lane_sel_bits(EX_DATA_WIDTH, LD_DATA_WIDTH);
    localparam int LSW       = (LANE_BITS > 0) ? LANE_BITS : 1;

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("READ_LATENCY out of range");
    end
    if (R * LD_DATA_WIDTH != EX_DATA_WIDTH || (1 << LANE_BITS) != R) begin : g_bad_ratio
        $error("EX_DATA_WIDTH must be a power-of-2 multiple of LD_DATA_WIDTH");
    end
    if ((1 << EX_ADDR_WIDTH) != EX_DEPTH) begin : g_bad_depth
        $error("EX_DEPTH must be a power of 2");
    end

    bank_state_t bank_st [2];
    bank_state_t bank_st_nxt [2];
    bank_idx_t   ld_bank_q, ld_bank_nxt;
    bank_idx_t   ex_bank_q, ex_bank_nxt;
    logic        err_ovr_q, err_ovr_nxt;
    logic        err_und_q, err_und_nxt;
    logic        commit_ok, release_ok;

    assign ld_ready      = (bank_st[ld_bank_q] == BANK_EMPTY);
    assign ex_bank_valid = (bank_st[ex_bank_q] == BANK_FULL);
    assign commit_ok     = ld_commit & ld_ready;
    assign release_ok    = ex_release & ex_bank_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            ld_bank_q  <= 1'b0;
            ex_bank_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_und_q  <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            ld_bank_q  <= ld_bank_nxt;
            ex_bank_q  <= ex_bank_nxt;
            err_ovr_q  <= err_ovr_nxt;
            err_und_q  <= err_und_nxt;
        end
    end

    // A commit needs an empty bank and a release a full one, so both succeeding
    // in one cycle always touch different banks.
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        ld_bank_nxt    = ld_bank_q;
        ex_bank_nxt    = ex_bank_q;
        err_ovr_nxt    = err_ovr_q | ((ld_wr_en | ld_commit) & ~ld_ready);
        err_und_nxt    = err_und_q | ((ex_rd_en | ex_release) & ~ex_bank_valid);
        if (commit_ok) begin
            bank_st_nxt[ld_bank_q] = BANK_FULL;
            ld_bank_nxt            = ~ld_bank_q;
        end
        if (release_ok) begin
            bank_st_nxt[ex_bank_q] = BANK_EMPTY;
            ex_bank_nxt            = ~ex_bank_q;
        end
    end

    logic [LSW-1:0]              lane;
    logic [R-1:0]                lane_we;
    logic [EX_ADDR_WIDTH:0]      wr_addr;
    logic [EX_ADDR_WIDTH:0]      rd_addr;
    logic                        rd_issue;
    logic [READ_LATENCY-1:0]     vld;
    logic [READ_LATENCY-1:0]     stage_en;

    if (LANE_BITS > 0) begin : g_lane
        assign lane = ld_addr[LSW-1:0];
    end else begin : g_no_lane
        assign lane = '0;
    end

    always_comb begin
        lane_we       = '0;
        lane_we[lane] = ld_wr_en & ld_ready;
    end

    assign wr_addr  = {ld_bank_q, ld_addr[LD_ADDR_WIDTH-1 -: EX_ADDR_WIDTH]};
    assign rd_addr  = {ex_bank_q, ex_addr};
    assign rd_issue = ex_rd_en & ex_bank_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= rd_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_comb begin
        stage_en[0] = rd_issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_en[i] = vld[i-1];
        end
    end

    bram_sdp_lane_core #(
        .LANE_WIDTH       (LD_DATA_WIDTH),
        .LANES            (R),
        .DEPTH            (2 * EX_DEPTH),
        .READ_LATENCY     (READ_LATENCY),
        .MEMORY_PRIMITIVE (MEMORY_PRIMITIVE)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .wr_lane_en (lane_we),
        .wr_addr    (wr_addr),
        .wr_data    (ld_data),
        .rd_addr    (rd_addr),
        .stage_en   (stage_en),
        .rd_data    (ex_data)
    );

    assign ex_data_valid = vld[READ_LATENCY-1];
    assign ld_bank       = ld_bank_q;
    assign ex_bank       = ex_bank_q;
    assign err_overrun   = err_ovr_q;
    assign err_underrun  = err_und_q;

endmodule

// File: doc/bram_pingpong_buf.md
Name: bram_pingpong_buf

Overview:
- Double-buffered (ping-pong) simple-dual-port buffer between the load engine (writer) and the execute array (reader).
- Two banks of EX_DEPTH words each. The loader fills one bank while the executor drains the other. Commit and release pulses hand banks over.
- Adds a narrow-write/wide-read ratio, configurable read latency with a valid pipeline, per-bank full flags, and sticky protocol-error flags.

Parameters:
- LD_DATA_WIDTH, 64: loader write word width.
- EX_DATA_WIDTH, 256: executor read word width. Must be an integer multiple R of LD_DATA_WIDTH, with R a power of 2.
- EX_DEPTH, 256: EX words per bank. Must be a power of 2.
- EX_ADDR_WIDTH, $clog2(EX_DEPTH): derived, not overridable.
- LD_ADDR_WIDTH, EX_ADDR_WIDTH+$clog2(R): derived, not overridable.
- READ_LATENCY, 2: read latency, range 1..3.
- MEMORY_PRIMITIVE, "auto": passed to the memory macro.

Ports:
- clk  in  1  single clock for both sides.
- rst  in  1  asynchronous, active-high reset.
- ld_wr_en  in  1  write strobe.
- ld_addr  in  LD_ADDR_WIDTH  narrow address within the current load bank.
- ld_data  in  LD_DATA_WIDTH  write data.
- ld_ready  out  1  current load bank is empty; writes are accepted.
- ld_commit  in  1  pulse: mark the load bank full and advance.
- ex_rd_en  in  1  read strobe.
- ex_addr  in  EX_ADDR_WIDTH  wide address within the current exec bank.
- ex_bank_valid  out  1  current exec bank is full and readable.
- ex_release  in  1  pulse: mark the exec bank empty and advance.
- ex_data  out  EX_DATA_WIDTH  read data.
- ex_data_valid  out  1  ex_data is valid this cycle.
- ld_bank  out  1  current load bank index.
- ex_bank  out  1  current exec bank index.
- err_overrun  out  1  sticky: write or commit attempted while ld_ready=0.
- err_underrun  out  1  sticky: read or release attempted while ex_bank_valid=0.

Behaviour:
- Reset (async assert, sync release):
  - full[1:0]=0, ld_bank=0, ex_bank=0.
  - ld_ready=1, ex_bank_valid=0.
  - ex_data_valid pipeline flushed to 0; ex_data=0.
  - Error flags cleared.
  - Memory contents are not cleared.
  - Reset mid-operation discards all handshake state; in-flight reads never assert valid.
- ld_ready = !full[ld_bank]. ex_bank_valid = full[ex_bank]. Both are combinational from the registered state.
- Write mapping:
  - Accepted when ld_wr_en & ld_ready.
  - Physical word = {ld_bank, ld_addr[LD_ADDR_WIDTH-1:log2 R]}.
  - Lane = ld_addr[log2 R-1:0]. Lane 0 occupies EX bits [LD_DATA_WIDTH-1:0].
  - Only that lane's write enable is asserted.
  - Writes while !ld_ready are dropped and set err_overrun.
- Read mapping:
  - Issued when ex_rd_en & ex_bank_valid, at physical word {ex_bank, ex_addr}.
  - ex_data and ex_data_valid appear exactly READ_LATENCY cycles after issue. Back-to-back reads give one result per cycle.
  - Reads while !ex_bank_valid are dropped (no valid pulse) and set err_underrun.
  - ex_data holds its last value when not valid.
- Commit: ld_commit & ld_ready sets full[ld_bank] and toggles ld_bank at the next edge. ld_commit & !ld_ready is ignored and sets err_overrun.
- Release: ex_release & ex_bank_valid clears full[ex_bank] and toggles ex_bank. ex_release & !ex_bank_valid is ignored and sets err_underrun.
- Simultaneous events:
  - Commit and release in the same cycle on different banks: both take effect.
  - Same bank (only possible when that bank is full): release takes effect; the commit is ignored, flagged as overrun.
  - Write and commit in the same cycle: the write lands in the bank being committed.
  - Read and release in the same cycle: the read is issued and its data is still delivered.
- Read-during-write on the same physical word cannot occur legally, because the banks are disjoint under the protocol. Data in that case is undefined.
- Bank indices wrap 1 to 0. At most 2 banks can be full; when both are full, ld_ready=0.

Decomposition:
- Package pingpong_buf_pkg holds:
  - the bank_idx_t typedef (1 bit);
  - the bank state enum BANK_EMPTY/BANK_FULL;
  - a function computing R and log2 R;
  - the legal READ_LATENCY range constants.
- One sub-module, bram_sdp_lane_core:
  - common-clock SDP memory of depth 2*EX_DEPTH and width EX_DATA_WIDTH;
  - per-lane write enables (R bits, lane width LD_DATA_WIDTH);
  - READ_LATENCY output registers.
- The top level holds the bank FSM, address and lane decode, valid shift register and error flags.

Test Plan:
- Fill bank 0 with R=4 narrow writes to ld_addr 0..3 carrying 0x11..,0x22..,0x33..,0x44.., then commit. Read ex_addr 0 -> ex_data={0x44..,0x33..,0x22..,0x11..} exactly 2 cycles later with valid=1; ex_bank_valid=1, ld_bank=1.
- Ping-pong streaming over 4 rounds, alternating commit and release → banks alternate 0,1,0,1; no error flags; every read word matches the scoreboard.
- Commit both banks without any release → ld_ready=0. A further write and commit set err_overrun=1; memory is unchanged.
- Issue ex_rd_en and ex_release with no full bank → no ex_data_valid, err_underrun=1, ex_bank stays 0.
- Release bank 0 and commit bank 1 in the same cycle → full becomes {1,0} as expected, ld_bank=0, ex_bank=1, no errors.
- Assert rst with 2 reads in flight → ex_data_valid stays 0 after release, full=0, ld_ready=1. Re-running the first scenario passes.
